axi_dma_rd_master: RTL and testbench
====================================

Name: axi_dma_rd_master

Overview:
- AXI4 read burst master that executes one read burst per request from the DMA read controller.
- On a one-cycle start pulse with an address, it issues one INCR burst of i_num_trans beats and streams the returned data downstream through a registered skid buffer.
- It pulses o_read_done after the last beat has been consumed downstream.
- It sits between the DMA read controller (upstream) and the AXI interconnect / on-chip buffer writer (downstream).

Parameters:
- AXI_WIDTH_AD, 32, AXI address width.
- AXI_WIDTH_DA, 64, AXI data width (power of two, 32..512).
- AXI_WIDTH_ID, 4, AXI ID width.
- BIT_TRANS, 18, width of the beat-count input.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- i_ctrl_read, in, 1, burst start, 1-cycle pulse.
- i_read_addr, in, AXI_WIDTH_AD, burst byte address.
- i_num_trans, in, BIT_TRANS, beats in this burst.
- o_read_done, out, 1, burst complete, 1-cycle pulse.
- o_busy, out, 1, high whenever state is not IDLE.
- o_rd_err, out, 1, sticky error flag.
- o_rd_data, out, AXI_WIDTH_DA, stream data.
- o_rd_data_vld, out, 1, stream valid.
- o_rd_data_last, out, 1, last beat of the burst.
- i_rd_data_rdy, in, 1, downstream ready.
- M_ARVALID / M_ARREADY, out/in, 1, AR handshake.
- M_ARADDR, out, AXI_WIDTH_AD, AR address.
- M_ARID, out, AXI_WIDTH_ID, constant 0.
- M_ARLEN, out, 8, AR burst length.
- M_ARSIZE, out, 3, constant log2(AXI_WIDTH_DA/8).
- M_ARBURST, out, 2, constant 2'b01 (INCR).
- M_RVALID / M_RREADY, in/out, 1, R handshake.
- M_RDATA, in, AXI_WIDTH_DA, R data.
- M_RRESP, in, 2, R response.
- M_RLAST, in, 1, R last.
- M_RID, in, AXI_WIDTH_ID, ignored.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rstn` is asynchronous and active-low.
- Reset values: all outputs 0 except constant M_ARSIZE and M_ARBURST. State is IDLE, counters are 0, o_rd_err is 0, skid buffer is empty.
- State machine: IDLE -> AR -> R -> DRAIN -> DONE -> IDLE.
- IDLE:
  - i_ctrl_read=1 latches the address and len = i_num_trans-1, clears o_rd_err, and enters AR.
  - If i_num_trans==0 or i_num_trans>256, no AXI traffic is issued: set o_rd_err and go straight to DONE.
  - i_ctrl_read in any other state is ignored.
- AR:
  - M_ARVALID=1 with M_ARADDR and M_ARLEN stable until M_ARREADY; the AR handshake moves to R.
  - Latency: start at cycle t gives M_ARVALID at t+1.
- R:
  - M_RREADY = skid buffer not full.
  - Each accepted beat increments a 9-bit beat counter and is pushed into the skid buffer.
  - The burst terminates on the first accepted beat where M_RLAST=1 or count==len, whichever comes first. That beat is tagged last; go to DRAIN.
  - If RLAST and count==len disagree, set o_rd_err.
  - Any accepted beat with M_RRESP!=2'b00 sets o_rd_err; its data is still forwarded.
- DRAIN: wait until the tagged beat is handshaked on the output (o_rd_data_vld && i_rd_data_rdy && o_rd_data_last), then go to DONE.
- DONE: o_read_done=1 for exactly one cycle, then IDLE. A new i_ctrl_read is accepted in the cycle after DONE.
- Data path:
  - 2-entry skid buffer; the output is registered and M_RREADY is registered.
  - Data, vld and last are all driven from the registered output.
  - Minimum added latency is 1 cycle from R handshake to o_rd_data_vld.
  - No beat is lost or duplicated under arbitrary i_rd_data_rdy toggling.
  - Sustained throughput is 1 beat/cycle when i_rd_data_rdy=1.
  - Beats arriving while not in R are never accepted (M_RREADY=0).
- Width and alignment rules:
  - len is truncated to 8 bits after range check.
  - 4 KB boundary crossing is not checked; the upstream controller guarantees it.
  - The address is passed unmodified; unaligned addresses are the issuer's responsibility.
- Reset mid-burst: immediate return to IDLE with all outputs cleared. Outstanding AXI beats are abandoned, since reset is system-wide.

Decomposition:
- Package axi_dma_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_AR=1, ST_R=2, ST_DRAIN=3, ST_DONE=4);
  - AXI constants BURST_INCR=2'b01 and RESP_OKAY=2'b00;
  - MAX_AXI_LEN=256.
- One sub-module: axi_skid_buf, a generic 2-entry valid/ready register slice with a WIDTH parameter, instantiated with WIDTH=AXI_WIDTH_DA+1 (data plus last).

Test Plan:
1. Basic burst: start with addr=0x1000_0040, num_trans=8; slave ARREADY after 2 cycles, 8 back-to-back beats, rdy=1.
   - Expect ARLEN=7, ARSIZE=3, ARBURST=1.
   - Expect 8 output beats in order with last on beat 8, one done pulse after the last handshake, and o_rd_err=0.
2. Backpressure: num_trans=16, i_rd_data_rdy random at 50%, RVALID random.
   - Expect all 16 data words delivered exactly once and in order, and M_RREADY never high with the buffer full.
3. Illegal length: num_trans=0, then num_trans=300.
   - Expect no ARVALID, a done pulse 2 cycles after start, and o_rd_err=1.
   - A following legal start clears o_rd_err.
4. Protocol error: num_trans=4, slave asserts RLAST on beat 3 and RRESP=2'b10 on beat 2.
   - Expect 3 beats out with last on beat 3, o_rd_err=1, and done pulsed.
5. Overlap and ignore: i_ctrl_read pulsed again during R.
   - Expect it ignored: a single AR and a single done.
   - A start in the cycle after done is accepted.
6. Reset mid-burst: rstn low after beat 5 of 8.
   - Expect all outputs 0 and state IDLE.
   - After release, a fresh 8-beat burst completes normally.

Source files
------------

// File: rtl/axi_dma_pkg.sv
// Shared state encoding, AXI constants and helpers for the DMA read master.
package axi_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } rd_state_e;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam int unsigned MAX_AXI_LEN = 32'd256;

  // AXI size encoding for a data bus of width_bits bits.
  function automatic logic [2:0] axi_size(input int unsigned width_bits);
    return 3'($clog2(width_bits / 32'd8));
  endfunction

endpackage

// File: rtl/axi_dma_rd_master_skid.sv
// Generic 2-entry valid/ready register slice: registered output, and an input
// ready that depends only on the skid register.
module axi_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_vld_q,  out_vld_d;
  logic [WIDTH-1:0] out_dat_q,  out_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_fire_s;
  logic             out_free_s;

  assign in_ready_o  = ~skid_vld_q;
  assign in_fire_s   = in_valid_i & ~skid_vld_q;
  assign out_free_s  = ~out_vld_q | out_ready_i;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_dat_q;

  // Next-state: refill output from skid first, otherwise park input in skid
  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (out_free_s) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (in_fire_s) begin
        out_vld_d = 1'b1;
        out_dat_d = in_data_i;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_data_i;
    end else begin
      skid_vld_d = skid_vld_q;
    end
  end

  // Slice registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= {WIDTH{1'b0}};
      skid_vld_q <= 1'b0;
      skid_dat_q <= {WIDTH{1'b0}};
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/axi_dma_rd_master.sv
// AXI4 read burst master: one INCR burst per start pulse, returned beats are
// streamed downstream through a registered skid buffer.
module axi_dma_rd_master
  import axi_dma_pkg::*;
#(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 64,
  parameter int AXI_WIDTH_ID = 4,
  parameter int BIT_TRANS    = 18
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_ctrl_read,
  input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
  input  logic [BIT_TRANS-1:0]    i_num_trans,
  output logic                    o_read_done,
  output logic                    o_busy,
  output logic                    o_rd_err,
  output logic [AXI_WIDTH_DA-1:0] o_rd_data,
  output logic                    o_rd_data_vld,
  output logic                    o_rd_data_last,
  input  logic                    i_rd_data_rdy,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
  output logic [AXI_WIDTH_ID-1:0] M_ARID,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RLAST,
  input  logic [AXI_WIDTH_ID-1:0] M_RID
);

  localparam logic [2:0]           AR_SIZE   = axi_size(AXI_WIDTH_DA);
  localparam logic [BIT_TRANS-1:0] MAX_LEN_W = BIT_TRANS'(MAX_AXI_LEN);
  localparam logic [BIT_TRANS-1:0] ONE_W     = {{(BIT_TRANS-1){1'b0}}, 1'b1};

  rd_state_e               state_q, state_d;
  logic [AXI_WIDTH_AD-1:0] addr_q,  addr_d;
  logic [7:0]              len_q,   len_d;
  logic [8:0]              cnt_q,   cnt_d;
  logic                    err_q,   err_d;
  logic                    busy_q;
  logic                    arvalid_q;
  logic                    done_q;

  logic [BIT_TRANS-1:0]    num_m1_s;
  logic                    len_bad_s;
  logic                    r_fire_s;
  logic                    hit_len_s;
  logic                    beat_last_s;
  logic                    skid_in_rdy_s;
  logic                    out_vld_s;
  logic [AXI_WIDTH_DA:0]   out_payload_s;
  logic                    out_fire_last_s;
  logic                    unused_s;

  assign num_m1_s        = i_num_trans - ONE_W;
  assign len_bad_s       = (i_num_trans == {BIT_TRANS{1'b0}}) || (i_num_trans > MAX_LEN_W);
  assign M_RREADY        = (state_q == ST_R) & skid_in_rdy_s;
  assign r_fire_s        = M_RVALID & M_RREADY;
  // The counter holds beats already accepted, so the final beat sees cnt == len.
  assign hit_len_s       = (cnt_q == {1'b0, len_q});
  assign beat_last_s     = M_RLAST | hit_len_s;
  assign out_fire_last_s = out_vld_s & i_rd_data_rdy & out_payload_s[AXI_WIDTH_DA];
  assign unused_s        = ^{M_RID, num_m1_s[BIT_TRANS-1:8]};

  // Burst sequencing and error tracking
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ctrl_read) begin
          cnt_d = 9'd0;
          if (len_bad_s) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            addr_d  = i_read_addr;
            len_d   = num_m1_s[7:0];
            state_d = ST_AR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (M_ARREADY) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (r_fire_s) begin
          cnt_d = cnt_q + 9'd1;
          if ((M_RRESP != RESP_OKAY) || (M_RLAST != hit_len_s)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (beat_last_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_R;
          end
        end else begin
          state_d = ST_R;
        end
      end
      ST_DRAIN: begin
        if (out_fire_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered control outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      addr_q    <= {AXI_WIDTH_AD{1'b0}};
      len_q     <= 8'd0;
      cnt_q     <= 9'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= (state_d != ST_IDLE);
      arvalid_q <= (state_d == ST_AR);
      done_q    <= (state_q == ST_DONE);
    end
  end

  axi_skid_buf #(
    .WIDTH (AXI_WIDTH_DA + 1)
  ) u_skid (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (M_RVALID & (state_q == ST_R)),
    .in_ready_o  (skid_in_rdy_s),
    .in_data_i   ({beat_last_s, M_RDATA}),
    .out_valid_o (out_vld_s),
    .out_ready_i (i_rd_data_rdy),
    .out_data_o  (out_payload_s)
  );

  assign o_rd_data      = out_payload_s[AXI_WIDTH_DA-1:0];
  assign o_rd_data_last = out_payload_s[AXI_WIDTH_DA];
  assign o_rd_data_vld  = out_vld_s;
  assign o_read_done    = done_q;
  assign o_busy         = busy_q;
  assign o_rd_err       = err_q;
  assign M_ARVALID      = arvalid_q;
  assign M_ARADDR       = addr_q;
  assign M_ARLEN        = len_q;
  assign M_ARID         = {AXI_WIDTH_ID{1'b0}};
  assign M_ARSIZE       = AR_SIZE;
  assign M_ARBURST      = BURST_INCR;

endmodule

// File: tb/tb_axi_dma_rd_master.sv
// Directed bench for axi_dma_rd_master with a negedge-driven AXI slave and
// downstream consumer.
`timescale 1ns/1ps
module tb_axi_dma_rd_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_ctrl_read;
  logic [31:0] i_read_addr;
  logic [17:0] i_num_trans;
  logic        o_read_done, o_busy, o_rd_err;
  logic [63:0] o_rd_data;
  logic        o_rd_data_vld, o_rd_data_last, i_rd_data_rdy;
  logic        M_ARVALID, M_ARREADY;
  logic [31:0] M_ARADDR;
  logic [3:0]  M_ARID;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic        M_RVALID, M_RREADY;
  logic [63:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RLAST;
  logic [3:0]  M_RID;

  always #5 clk = ~clk;

  axi_dma_rd_master #(.AXI_WIDTH_AD(32), .AXI_WIDTH_DA(64), .AXI_WIDTH_ID(4), .BIT_TRANS(18)) dut (
    .clk(clk), .rstn(rstn), .i_ctrl_read(i_ctrl_read), .i_read_addr(i_read_addr),
    .i_num_trans(i_num_trans), .o_read_done(o_read_done), .o_busy(o_busy), .o_rd_err(o_rd_err),
    .o_rd_data(o_rd_data), .o_rd_data_vld(o_rd_data_vld), .o_rd_data_last(o_rd_data_last),
    .i_rd_data_rdy(i_rd_data_rdy), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_ARADDR(M_ARADDR), .M_ARID(M_ARID), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
    .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RID(M_RID)
  );

  int checks = 0;
  int errors = 0;

  // Slave / consumer configuration
  int          s_ar_delay = 0, s_nbeats = 0, s_rlast_at = 0, s_err_at = 0;
  bit          s_rand_rv = 1'b0, s_rand_rdy = 1'b0;
  logic [63:0] s_base = 64'd0;

  // Observations
  int          ar_count = 0, done_count = 0, r_acc = 0, o_del = 0, occ_viol = 0;
  logic [63:0] got_data[$];
  bit          got_last[$];

  bit b_ar_f, b_r_f, b_r_l, b_o_f, b_in_burst;
  int b_ar_wait, b_beat;

  // AXI slave, downstream consumer and monitor, all acting at the falling edge
  initial begin : bfm
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = 64'd0; M_RRESP = 2'b00;
    M_RLAST = 1'b0; M_RID = 4'd0; i_rd_data_rdy = 1'b0;
    b_ar_f = 1'b0; b_r_f = 1'b0; b_r_l = 1'b0; b_o_f = 1'b0; b_in_burst = 1'b0;
    b_ar_wait = 0; b_beat = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        b_ar_f = 1'b0; b_r_f = 1'b0; b_r_l = 1'b0; b_o_f = 1'b0; b_in_burst = 1'b0;
        b_ar_wait = 0; b_beat = 0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00;
      end else begin
        if (b_ar_f) begin ar_count++; b_in_burst = 1'b1; b_beat = 0; b_ar_wait = 0; end
        if (b_r_f) begin
          r_acc++; b_beat++;
          if (b_r_l || b_beat >= s_nbeats) b_in_burst = 1'b0;
        end
        if (b_o_f) o_del++;
        if (o_read_done) done_count++;
        if (M_ARVALID && !b_in_burst && b_ar_wait >= s_ar_delay) M_ARREADY = 1'b1;
        else begin
          M_ARREADY = 1'b0;
          if (M_ARVALID) b_ar_wait++;
        end
        if (M_RVALID && !b_r_f) begin
          M_RVALID = 1'b1;
        end else if (b_in_burst && b_beat < s_nbeats && (!s_rand_rv || $urandom_range(0, 1) == 1)) begin
          M_RVALID = 1'b1;
          M_RDATA  = s_base + 64'(b_beat);
          M_RLAST  = (b_beat + 1 == s_rlast_at);
          M_RRESP  = (b_beat + 1 == s_err_at) ? 2'b10 : 2'b00;
        end else begin
          M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00;
        end
        i_rd_data_rdy = s_rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (M_RREADY && (r_acc - o_del) >= 2) occ_viol++;
        b_ar_f = M_ARVALID && M_ARREADY;
        b_r_f  = M_RVALID && M_RREADY;
        b_r_l  = M_RLAST;
        b_o_f  = o_rd_data_vld && i_rd_data_rdy;
        if (b_o_f) begin got_data.push_back(o_rd_data); got_last.push_back(o_rd_data_last); end
      end
    end
  end

  task automatic clear_obs();
    ar_count = 0; done_count = 0; r_acc = 0; o_del = 0; occ_viol = 0;
    got_data.delete(); got_last.delete();
  endtask

  task automatic start(input logic [31:0] addr, input logic [17:0] n);
    @(negedge clk);
    i_ctrl_read = 1'b1; i_read_addr = addr; i_num_trans = n;
    @(negedge clk);
    i_ctrl_read = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 400 && done_count == d0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({o_read_done, o_busy, o_rd_err, o_rd_data_vld, o_rd_data_last, M_ARVALID, M_RREADY} !== 7'd0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {o_read_done, o_busy, o_rd_err, o_rd_data_vld, o_rd_data_last, M_ARVALID, M_RREADY}); end
    checks++; if ({o_rd_data, M_ARADDR, M_ARLEN, M_ARID} !== 108'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {o_rd_data, M_ARADDR, M_ARLEN, M_ARID}); end
    checks++; if (M_ARSIZE !== 3'd3) begin errors++; $display("FAIL reset_arsize got %0d exp 3", M_ARSIZE); end
    checks++; if (M_ARBURST !== 2'b01) begin errors++; $display("FAIL reset_arburst got %0d exp 1", M_ARBURST); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_basic();
    clear_obs();
    s_ar_delay = 2; s_nbeats = 8; s_rlast_at = 8; s_err_at = 0; s_base = 64'hA000_0000_0000_0000;
    start(32'h1000_0040, 18'd8);
    checks++; if (M_ARVALID !== 1'b1) begin errors++; $display("FAIL basic_arvalid got %b exp 1", M_ARVALID); end
    checks++; if (M_ARADDR !== 32'h1000_0040) begin errors++; $display("FAIL basic_araddr got %h exp 10000040", M_ARADDR); end
    checks++; if (M_ARLEN !== 8'd7) begin errors++; $display("FAIL basic_arlen got %0d exp 7", M_ARLEN); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", o_busy); end
    wait_done(0);
    checks++; if (done_count !== 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_count); end
    checks++; if (ar_count !== 1) begin errors++; $display("FAIL basic_ar got %0d exp 1", ar_count); end
    checks++; if (got_data.size() !== 8) begin errors++; $display("FAIL basic_count got %0d exp 8", got_data.size()); end
    if (got_data.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (got_data[i] !== 64'hA000_0000_0000_0000 + 64'(i)) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, got_data[i], 64'hA000_0000_0000_0000 + 64'(i)); end
        checks++; if (got_last[i] !== (i == 7)) begin errors++; $display("FAIL basic_last[%0d] got %b exp %b", i, got_last[i], (i == 7)); end
      end
    end
    checks++; if (o_rd_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", o_rd_err); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", o_busy); end
  endtask

  task automatic test_backpressure();
    clear_obs();
    s_ar_delay = 0; s_nbeats = 16; s_rlast_at = 16; s_err_at = 0; s_base = 64'h0000_0000_5555_0000;
    s_rand_rv = 1'b1; s_rand_rdy = 1'b1;
    start(32'h2000_0000, 18'd16);
    wait_done(0);
    s_rand_rv = 1'b0; s_rand_rdy = 1'b0;
    checks++; if (got_data.size() !== 16) begin errors++; $display("FAIL bp_count got %0d exp 16", got_data.size()); end
    if (got_data.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (got_data[i] !== 64'h0000_0000_5555_0000 + 64'(i) || got_last[i] !== (i == 15)) begin errors++; $display("FAIL bp_beat[%0d] got %h/%b exp %h/%b", i, got_data[i], got_last[i], 64'h0000_0000_5555_0000 + 64'(i), (i == 15)); end
      end
    end
    checks++; if (occ_viol !== 0) begin errors++; $display("FAIL bp_rready_full got %0d exp 0", occ_viol); end
    checks++; if (done_count !== 1 || o_rd_err !== 1'b0) begin errors++; $display("FAIL bp_done_err got %0d/%b exp 1/0", done_count, o_rd_err); end
  endtask

  task automatic test_illegal_len();
    logic [17:0] bad_n [2];
    bad_n[0] = 18'd0; bad_n[1] = 18'd300;
    for (int j = 0; j < 2; j++) begin
      clear_obs();
      start(32'h3000_0000, bad_n[j]);
      checks++; if (o_read_done !== 1'b0 || M_ARVALID !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL illegal%0d_t1 got done=%b arv=%b busy=%b exp 0 0 1", j, o_read_done, M_ARVALID, o_busy); end
      @(negedge clk);
      checks++; if (o_read_done !== 1'b1 || o_rd_err !== 1'b1) begin errors++; $display("FAIL illegal%0d_t2 got done=%b err=%b exp 1 1", j, o_read_done, o_rd_err); end
      @(negedge clk);
      checks++; if (o_read_done !== 1'b0 || ar_count !== 0) begin errors++; $display("FAIL illegal%0d_t3 got done=%b ar=%0d exp 0 0", j, o_read_done, ar_count); end
      if (j == 0) begin
        s_ar_delay = 0; s_nbeats = 2; s_rlast_at = 2; s_err_at = 0; s_base = 64'h77;
        start(32'h3000_1000, 18'd2);
        checks++; if (o_rd_err !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b exp 0", o_rd_err); end
        wait_done(done_count);
        checks++; if (got_data.size() !== 2 || o_rd_err !== 1'b0) begin errors++; $display("FAIL illegal_legal got n=%0d err=%b exp 2 0", got_data.size(), o_rd_err); end
      end
    end
  endtask

  task automatic test_protocol_err();
    clear_obs();
    s_ar_delay = 1; s_nbeats = 3; s_rlast_at = 3; s_err_at = 2; s_base = 64'hBEEF_0000;
    start(32'h4000_0000, 18'd4);
    wait_done(0);
    checks++; if (got_data.size() !== 3) begin errors++; $display("FAIL perr_count got %0d exp 3", got_data.size()); end
    if (got_data.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_data[i] !== 64'hBEEF_0000 + 64'(i) || got_last[i] !== (i == 2)) begin errors++; $display("FAIL perr_beat[%0d] got %h/%b exp %h/%b", i, got_data[i], got_last[i], 64'hBEEF_0000 + 64'(i), (i == 2)); end
      end
    end
    checks++; if (o_rd_err !== 1'b1 || done_count !== 1) begin errors++; $display("FAIL perr_err_done got %b/%0d exp 1/1", o_rd_err, done_count); end
  endtask

  task automatic test_overlap();
    clear_obs();
    s_ar_delay = 1; s_nbeats = 8; s_rlast_at = 8; s_err_at = 0; s_base = 64'hC000;
    start(32'h5000_0000, 18'd8);
    for (int k = 0; k < 100 && r_acc < 2; k++) @(negedge clk);
    start(32'h6000_0000, 18'd4);
    for (int k = 0; k < 200 && o_read_done !== 1'b1; k++) @(negedge clk);
    checks++; if (o_read_done !== 1'b1) begin errors++; $display("FAIL ovl_done_seen got %b exp 1", o_read_done); end
    checks++; if (M_ARADDR !== 32'h5000_0000) begin errors++; $display("FAIL ovl_addr_kept got %h exp 50000000", M_ARADDR); end
    s_nbeats = 2; s_rlast_at = 2; s_base = 64'hD000;
    i_ctrl_read = 1'b1; i_read_addr = 32'h7000_0100; i_num_trans = 18'd2;
    @(negedge clk);
    i_ctrl_read = 1'b0;
    checks++; if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h7000_0100 || M_ARLEN !== 8'd1) begin errors++; $display("FAIL ovl_next_start got %b %h %0d exp 1 70000100 1", M_ARVALID, M_ARADDR, M_ARLEN); end
    wait_done(done_count);
    checks++; if (ar_count !== 2 || done_count !== 2) begin errors++; $display("FAIL ovl_counts got ar=%0d done=%0d exp 2 2", ar_count, done_count); end
    checks++; if (got_data.size() !== 10) begin errors++; $display("FAIL ovl_beats got %0d exp 10", got_data.size()); end
  endtask

  task automatic test_reset_mid_burst();
    clear_obs();
    s_ar_delay = 0; s_nbeats = 8; s_rlast_at = 8; s_err_at = 0; s_base = 64'hE000;
    start(32'h8000_0000, 18'd8);
    for (int k = 0; k < 100 && r_acc < 5; k++) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if ({o_read_done, o_busy, o_rd_err, o_rd_data_vld, o_rd_data_last, M_ARVALID, M_RREADY} !== 7'd0) begin errors++; $display("FAIL rstmid_ctrl got %b exp 0", {o_read_done, o_busy, o_rd_err, o_rd_data_vld, o_rd_data_last, M_ARVALID, M_RREADY}); end
    checks++; if ({o_rd_data, M_ARADDR, M_ARLEN} !== 104'd0) begin errors++; $display("FAIL rstmid_data got %h exp 0", {o_rd_data, M_ARADDR, M_ARLEN}); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    clear_obs();
    s_base = 64'hF000;
    start(32'h9000_0000, 18'd8);
    wait_done(0);
    checks++; if (got_data.size() !== 8 || done_count !== 1 || o_rd_err !== 1'b0) begin errors++; $display("FAIL rstmid_after got n=%0d done=%0d err=%b exp 8 1 0", got_data.size(), done_count, o_rd_err); end
    if (got_data.size() == 8) begin
      checks++; if (got_data[0] !== 64'hF000 || got_data[7] !== 64'hF007 || got_last[7] !== 1'b1) begin errors++; $display("FAIL rstmid_data_after got %h %h %b exp f000 f007 1", got_data[0], got_data[7], got_last[7]); end
    end
  endtask

  initial begin
    i_ctrl_read = 1'b0; i_read_addr = 32'd0; i_num_trans = 18'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal_len();
    test_protocol_err();
    test_overlap();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
